// File: rtl/key_conditioner_pkg.sv
// Shared constants and types for the push-button conditioning path.
// Board key roles, default timing at 50 MHz and the per-key FSM state type.
package key_conditioner_pkg;

    localparam int CLK_HZ = 50_000_000;

    localparam int KEY_START  = 0;
    localparam int KEY_LEFT   = 1;
    localparam int KEY_RIGHT  = 2;
    localparam int KEY_ATTACK = 3;
    localparam int NUM_BOARD_KEYS = 4;

    // 20 ms debounce, 0.5 s to first repeat, then 10 repeats per second.
    localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 50;
    localparam int DEFAULT_REPEAT_DELAY    = CLK_HZ / 2;
    localparam int DEFAULT_REPEAT_PERIOD   = CLK_HZ / 10;
    localparam int DEFAULT_CNT_W           = 25;

    typedef enum logic {
        KEY_RELEASED = 1'b0,
        KEY_HELD     = 1'b1
    } key_state_t;

endpackage

// File: rtl/key_conditioner_if.sv
// Key bundle between the board pins and the conditioner.
// The master drives the raw active-low keys; the slave returns the conditioned view.
interface key_conditioner_if #(
    parameter int NUM_KEYS = key_conditioner_pkg::NUM_BOARD_KEYS
);

    logic [NUM_KEYS-1:0] key_n_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_repeat;
    logic                any_level;
    logic                any_press;

    modport master (
        output key_n_raw,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_repeat,
        input  any_level,
        input  any_press
    );

    modport slave (
        input  key_n_raw,
        output key_level,
        output key_press,
        output key_release,
        output key_repeat,
        output any_level,
        output any_press
    );

endinterface

// File: rtl/key_channel.sv
// One conditioned key: 2-FF synchronizer, debounce counter and press/hold/repeat FSM.
// level_nxt/press_nxt expose next-state values so the top can register aligned OR reductions.
module key_channel
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_raw,
    output logic level_nxt,
    output logic press_nxt,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    // Limits are held as "last count value" so the compare needs no subtraction.
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam bit               REPEAT_ON   = (REPEAT_DELAY > 0);

    logic [1:0]       sync_n;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_last;
    key_state_t       state;
    logic             mismatch;
    logic             flip;

    assign mismatch  = (~sync_n[1]) != key_level;
    assign flip      = mismatch && (deb_cnt >= DEB_LAST);
    assign level_nxt = key_level ^ flip;
    assign press_nxt = flip && (state == KEY_RELEASED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_n      <= 2'b11;
            deb_cnt     <= '0;
            rep_cnt     <= '0;
            rep_last    <= DELAY_LAST;
            state       <= KEY_RELEASED;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            sync_n      <= {sync_n[0], key_n_raw};
            key_level   <= level_nxt;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;

            // Any agreement with the stable state discards the partial count.
            if (!mismatch || flip) begin
                deb_cnt <= '0;
            end else if (deb_cnt != CNT_MAX) begin
                deb_cnt <= deb_cnt + CNT_ONE;
            end

            case (state)
                KEY_RELEASED: begin
                    if (flip) begin
                        state     <= KEY_HELD;
                        key_press <= 1'b1;
                        rep_cnt   <= '0;
                        rep_last  <= DELAY_LAST;
                    end
                end
                KEY_HELD: begin
                    if (flip) begin
                        state       <= KEY_RELEASED;
                        key_release <= 1'b1;
                        rep_cnt     <= '0;
                        rep_last    <= DELAY_LAST;
                    end else if (REPEAT_ON && (rep_cnt >= rep_last)) begin
                        key_repeat <= 1'b1;
                        rep_cnt    <= '0;
                        rep_last   <= PERIOD_LAST;
                    end else if (rep_cnt != CNT_MAX) begin
                        rep_cnt <= rep_cnt + CNT_ONE;
                    end
                end
                default: state <= KEY_RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions the active-low board keys into active-high level, press, release and repeat pulses.
// Holds only the per-key channels and the registered any_level/any_press reductions.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int NUM_KEYS        = NUM_BOARD_KEYS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    key_conditioner_if.slave  kif
);

    logic [NUM_KEYS-1:0] level_nxt;
    logic [NUM_KEYS-1:0] press_nxt;
    logic [NUM_KEYS-1:0] level_q;
    logic [NUM_KEYS-1:0] press_q;
    logic [NUM_KEYS-1:0] release_q;
    logic [NUM_KEYS-1:0] repeat_q;
    logic                any_level_q;
    logic                any_press_q;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .CNT_W           (CNT_W)
        ) u_channel (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_n_raw   (kif.key_n_raw[i]),
            .level_nxt   (level_nxt[i]),
            .press_nxt   (press_nxt[i]),
            .key_level   (level_q[i]),
            .key_press   (press_q[i]),
            .key_release (release_q[i]),
            .key_repeat  (repeat_q[i])
        );
    end

    // Reduced from next-state values so they land in the same cycle as the per-key flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_level_q <= 1'b0;
            any_press_q <= 1'b0;
        end else begin
            any_level_q <= |level_nxt;
            any_press_q <= |press_nxt;
        end
    end

    assign kif.key_level   = level_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_repeat  = repeat_q;
    assign kif.any_level   = any_level_q;
    assign kif.any_press   = any_press_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: pulse events are scoreboarded by cycle number.
// dut uses REPEAT_DELAY=10; dut_norep uses REPEAT_DELAY=0 on its own key bus.
module tb_key_conditioner;

    localparam int NK = 4;
    localparam int LAT = 6;
    localparam int RDELAY = 10;
    localparam int RPERIOD = 3;

    localparam int EV_PRESS = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_REPEAT = 2;
    localparam int EV_ANY = 3;

    typedef struct {
        int dut_id;
        int key;
        int hold;
        int exp_press;
        int exp_repeats;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int exp_q[$];
    int obs_q[$];
    vec_t vecs[7];

    key_conditioner_if #(.NUM_KEYS(NK)) bus ();
    key_conditioner_if #(.NUM_KEYS(NK)) bus0 ();

    key_conditioner #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(RDELAY),
        .REPEAT_PERIOD(RPERIOD), .CNT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .kif(bus)
    );

    key_conditioner #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0),
        .REPEAT_PERIOD(RPERIOD), .CNT_W(8)
    ) dut_norep (
        .clk(clk), .reset_n(reset_n), .kif(bus0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int enc(int c, int d, int kind, int key);
        return c * 32 + d * 16 + kind * 4 + key;
    endfunction

    // Record every pulse seen on either DUT, tagged with the cycle it appeared in.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < NK; i++) begin
                if (bus.key_press[i])    obs_q.push_back(enc(cyc, 0, EV_PRESS, i));
                if (bus.key_release[i])  obs_q.push_back(enc(cyc, 0, EV_RELEASE, i));
                if (bus.key_repeat[i])   obs_q.push_back(enc(cyc, 0, EV_REPEAT, i));
                if (bus0.key_press[i])   obs_q.push_back(enc(cyc, 1, EV_PRESS, i));
                if (bus0.key_release[i]) obs_q.push_back(enc(cyc, 1, EV_RELEASE, i));
                if (bus0.key_repeat[i])  obs_q.push_back(enc(cyc, 1, EV_REPEAT, i));
            end
            if (bus.any_press)  obs_q.push_back(enc(cyc, 0, EV_ANY, 0));
            if (bus0.any_press) obs_q.push_back(enc(cyc, 1, EV_ANY, 0));
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic pushExp(input int c, input int d, input int kind, input int key);
        exp_q.push_back(enc(c, d, kind, key));
    endtask

    task automatic checkScoreboard(input string name);
        int e;
        int o;
        exp_q.sort();
        obs_q.sort();
        checkOutput({name, " event count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checkOutput($sformatf("%s event cyc/dut/kind/key", name), o, e);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic driveKey(input int d, input int key, input logic val);
        if (d == 0) bus.key_n_raw[key] = val;
        else        bus0.key_n_raw[key] = val;
    endtask

    function automatic int levelBit(input int d, input int key);
        return (d == 0) ? int'(bus.key_level[key]) : int'(bus0.key_level[key]);
    endfunction

    function automatic int allOutputs();
        return int'({bus.key_level, bus.key_press, bus.key_release, bus.key_repeat,
                     bus.any_level, bus.any_press}) |
               int'({bus0.key_level, bus0.key_press, bus0.key_release, bus0.key_repeat,
                     bus0.any_level, bus0.any_press});
    endfunction

    task automatic applyStimulus(input int idx, input vec_t v);
        int a;
        @(negedge clk);
        a = cyc;
        driveKey(v.dut_id, v.key, 1'b0);
        if (v.exp_press != 0) begin
            pushExp(a + LAT, v.dut_id, EV_PRESS, v.key);
            pushExp(a + LAT, v.dut_id, EV_ANY, 0);
            for (int k = 0; k < v.exp_repeats; k++)
                pushExp(a + LAT + RDELAY + k * RPERIOD, v.dut_id, EV_REPEAT, v.key);
            pushExp(a + v.hold + LAT, v.dut_id, EV_RELEASE, v.key);
        end
        for (int j = 1; j <= v.hold + 20; j++) begin
            @(negedge clk);
            if (j == v.hold) driveKey(v.dut_id, v.key, 1'b1);
            if (j == LAT) checkOutput($sformatf("vec%0d level", idx), levelBit(v.dut_id, v.key), v.exp_press);
        end
        checkScoreboard($sformatf("vec%0d", idx));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c;
        vecs[0] = '{dut_id: 0, key: 0, hold: 20, exp_press: 1, exp_repeats: 4};
        vecs[1] = '{dut_id: 0, key: 1, hold: 11, exp_press: 1, exp_repeats: 1};
        vecs[2] = '{dut_id: 0, key: 2, hold: 3,  exp_press: 0, exp_repeats: 0};
        vecs[3] = '{dut_id: 0, key: 3, hold: 4,  exp_press: 1, exp_repeats: 0};
        vecs[4] = '{dut_id: 0, key: 2, hold: 5,  exp_press: 1, exp_repeats: 0};
        vecs[5] = '{dut_id: 0, key: 1, hold: 17, exp_press: 1, exp_repeats: 3};
        vecs[6] = '{dut_id: 1, key: 0, hold: 50, exp_press: 1, exp_repeats: 0};

        // All keys held through reset: reported as fresh presses after deassert.
        reset_n = 1'b0;
        bus.key_n_raw = '0;
        bus0.key_n_raw = '1;
        repeat (3) @(negedge clk);
        checkOutput("outputs in reset", allOutputs(), 0);
        mon_en = 1'b1;
        @(negedge clk);
        c = cyc;
        reset_n = 1'b1;
        for (int i = 0; i < NK; i++) pushExp(c + LAT, 0, EV_PRESS, i);
        pushExp(c + LAT, 0, EV_ANY, 0);
        repeat (LAT - 1) @(negedge clk);
        checkOutput("level before latency", int'(bus.key_level), 0);
        @(negedge clk);
        checkOutput("level after reset", int'(bus.key_level), 15);
        checkOutput("any_level after reset", int'(bus.any_level), 1);
        checkOutput("any_press at press", int'(bus.any_press), 1);
        @(negedge clk);
        checkOutput("any_press one cycle", int'(bus.any_press), 0);
        @(negedge clk);
        bus.key_n_raw = '1;
        for (int i = 0; i < NK; i++) pushExp(c + 8 + LAT, 0, EV_RELEASE, i);
        repeat (12) @(negedge clk);
        checkOutput("any_level released", int'(bus.any_level), 0);
        checkScoreboard("reset_held");

        for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i]);

        // Bounce 0,1,0,1 then steady low on key1.
        @(negedge clk);
        c = cyc;
        driveKey(0, 1, 1'b0);
        @(negedge clk); driveKey(0, 1, 1'b1);
        @(negedge clk); driveKey(0, 1, 1'b0);
        @(negedge clk); driveKey(0, 1, 1'b1);
        @(negedge clk); driveKey(0, 1, 1'b0);
        pushExp(c + 4 + LAT, 0, EV_PRESS, 1);
        pushExp(c + 4 + LAT, 0, EV_ANY, 0);
        repeat (8) @(negedge clk);
        checkScoreboard("bounce_press");
        driveKey(0, 1, 1'b1);
        pushExp(c + 12 + LAT, 0, EV_RELEASE, 1);
        repeat (12) @(negedge clk);
        checkScoreboard("bounce_release");

        // key3 held, reset pulsed at repeat count 7, repeat schedule restarts.
        @(negedge clk);
        c = cyc;
        driveKey(0, 3, 1'b0);
        pushExp(c + LAT, 0, EV_PRESS, 3);
        pushExp(c + LAT, 0, EV_ANY, 0);
        repeat (LAT + 7) @(negedge clk);
        checkOutput("key3 level before reset", levelBit(0, 3), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("outputs async reset", allOutputs(), 0);
        repeat (2) @(negedge clk);
        checkScoreboard("pre_reset");
        @(negedge clk);
        c = cyc;
        reset_n = 1'b1;
        pushExp(c + LAT, 0, EV_PRESS, 3);
        pushExp(c + LAT, 0, EV_ANY, 0);
        pushExp(c + LAT + RDELAY, 0, EV_REPEAT, 3);
        pushExp(c + LAT + RDELAY + RPERIOD, 0, EV_REPEAT, 3);
        pushExp(c + 14 + LAT, 0, EV_RELEASE, 3);
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (j == 14) driveKey(0, 3, 1'b1);
        end
        checkScoreboard("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
